cnt_seq_ctrl: RTL and testbench
===============================

Name: cnt_seq_ctrl

Overview:
Sequencer for the N-bit loadable up/down counter (RESET/LD/UP/DIN in, count out, synchronous, counts on every clock edge).
- Accepts a run command over a valid/ready handshake, loads the start value, and steps the counter toward an end value under a tick enable.
- Supports pause and abort, reports terminal count, and optionally auto-reloads.
- Holds the counter between steps by reloading its own value, because the counter has no enable.

Parameters:
N, 4, counter width; must match the controlled counter.
ITER_W, 8, width of the completed-iteration counter.

Ports:
clk  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_start  in  N  start value.
cmd_end  in  N  terminal value.
cmd_up  in  1  1 = count up, 0 = count down.
cmd_reload  in  1  1 = auto-reload on terminal count.
tick_en  in  1  advance the counter this cycle (RUN only).
pause  in  1  level; hold the count while high.
abort  in  1  pulse; clear the counter and return to IDLE.
cnt_q  in  N  count fed back from the counter.
cnt_rst  out  1  drives counter RESET.
cnt_ld  out  1  drives counter LD.
cnt_up  out  1  drives counter UP.
cnt_din  out  N  drives counter DIN.
busy  out  1  state is LOAD, RUN or PAUSE.
done  out  1  level; state is DONE.
term  out  1  one-cycle pulse at terminal count.
iter_cnt  out  ITER_W  completed iterations; saturates at all-ones.

Behaviour:
- States: IDLE, CLR, LOAD, RUN, PAUSE, DONE.
- Reset (RESET_N low, async):
  - State goes to IDLE.
  - Latched start, end, up and reload go to 0; iter_cnt goes to 0.
  - cnt_rst = 1 combinationally while RESET_N is low.
  - All other outputs are 0.
- Hold encoding: cnt_ld = 1, cnt_din = cnt_q, cnt_rst = 0. It is used in every state and cycle not listed below.
- cnt_up always drives the latched direction.
- cmd_ready = 1 only in IDLE and DONE.
- Command accept: cmd_valid && cmd_ready at edge E0.
  - Latch all cmd_* fields and clear iter_cnt.
  - Next state is LOAD.
- LOAD (1 cycle): cnt_ld = 1, cnt_din = latched start; next state is RUN. The counter holds start from E1 onward.
- RUN, evaluated in priority order:
  - cnt_q == end: term = 1, iter_cnt increments (saturating).
    - If reload: cnt_ld = 1, cnt_din = start, stay in RUN.
    - Else: hold, next state is DONE.
  - Else if pause: hold, next state is PAUSE.
  - Else if tick_en: cnt_ld = 0, so the counter steps ±1 at the next edge with natural mod-2^N wrap (0xF+1 -> 0x0, 0x0-1 -> 0xF).
  - Else: hold.
- PAUSE: hold; when pause = 0, next state is RUN. The terminal check resumes in the first RUN cycle.
- DONE: hold, done = 1. A new command goes to LOAD; abort goes to CLR.
- abort: has priority over everything in any non-reset state. Next state is CLR.
- CLR (1 cycle): cnt_rst = 1, cnt_ld = 0; next state is IDLE, so the counter is 0 from the following edge.
- Boundaries:
  - start == end: term fires in the first RUN cycle with zero steps.
  - The end value is always reachable modulo 2^N, so there is no lockup.
  - A command during busy is not accepted (cmd_ready = 0); the requester holds cmd_valid.
  - Timing with tick_en = 1 from E1: term fires in RUN cycle k = (end - start) mod 2^N if up, (start - end) mod 2^N if down.
  - Reload with tick_en = 1: period is distance + 1 cycles (the reload cycle consumes one edge).

Decomposition:
- Package cnt_seq_pkg holds:
  - state_t enum (IDLE, CLR, LOAD, RUN, PAUSE, DONE);
  - localparam default N;
  - a cmd_t struct packing start, end, up and reload.
- No sub-module in the controller. The bench instantiates the existing N-bit counter as the DUT partner, with cnt_q wired back.

Test Plan:
1. N=4, cmd start=3, end=7, up, tick_en=1 -> term pulse 4 cycles after entering RUN; cnt_q=7 in DONE; done=1; iter_cnt=1; cnt_q stays at 7 afterwards.
2. Down from 2 to 14 -> counter passes 1, 0, 15 (wrap) and term fires at 14 after 4 steps.
3. start=0, end=3, reload=1, up, run 20 cycles -> term every 4 cycles, cnt_q sequence 0,1,2,3,0,…, iter_cnt=5 after 5 terms.
4. Pause high for 6 cycles mid-run at cnt_q=5, and tick_en toggling 1010 -> cnt_q frozen at 5 during the pause, one step per tick_en=1 cycle otherwise.
5. Abort at cnt_q=9 during RUN -> CLR cycle with cnt_rst=1, cnt_q=0 next, state IDLE, cmd_ready=1.
6. RESET_N asserted mid-RUN, asynchronously between edges -> busy=0 and cnt_rst=1 immediately, state IDLE; start=end=5 command after release -> term fires in the first RUN cycle.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and the latched command.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cnt_seq_pkg;

  // Width of the controlled counter; cmd_t fields are sized from it.
  localparam int CNT_N = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // One accepted run command, held for the whole run.
  typedef struct packed {
    logic [CNT_N-1:0] start;
    logic [CNT_N-1:0] stop;
    logic             up;
    logic             reload;
  } cmd_t;

endpackage

// File: rtl/cnt_seq_ctrl.sv
// Sequencer driving an enable-less loadable up/down counter from start to end under tick_en.
// Latency: accept edge -> 1 LOAD cycle -> counter holds start; term is combinational on cnt_q == end.
// Backpressure: cmd_ready only in IDLE/DONE (and not during abort); requester holds cmd_valid otherwise.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int N      = CNT_N,  // must equal CNT_N, cmd_t is sized from it
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N-1:0]      cmd_start,
  input  logic [N-1:0]      cmd_end,
  input  logic              cmd_up,
  input  logic              cmd_reload,
  input  logic              tick_en,
  input  logic              pause,
  input  logic              abort,
  input  logic [N-1:0]      cnt_q,
  output logic              cnt_rst,
  output logic              cnt_ld,
  output logic              cnt_up,
  output logic [N-1:0]      cnt_din,
  output logic              busy,
  output logic              done,
  output logic              term,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t state;
  state_t state_nxt;
  cmd_t   cmd_q;
  logic   accept;
  logic   iter_inc;

  // Next state and counter drive; the counter has no enable, so "hold" means reloading cnt_q.
  always_comb begin
    state_nxt = state;
    cnt_rst   = 1'b0;
    cnt_ld    = 1'b1;
    cnt_din   = cnt_q;
    term      = 1'b0;
    iter_inc  = 1'b0;
    accept    = 1'b0;
    // Ready is withdrawn while abort is high so a handshake is never dropped.
    cmd_ready = ((state == IDLE) || (state == DONE)) && !abort;

    if (abort) begin
      state_nxt = CLR;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end
        end
        CLR: begin
          cnt_rst   = 1'b1;
          cnt_ld    = 1'b0;
          state_nxt = IDLE;
        end
        LOAD: begin
          cnt_din   = cmd_q.start;
          state_nxt = RUN;
        end
        RUN: begin
          if (cnt_q == cmd_q.stop) begin
            term     = 1'b1;
            iter_inc = 1'b1;
            if (cmd_q.reload) begin
              cnt_din = cmd_q.start;
            end else begin
              state_nxt = DONE;
            end
          end else if (pause) begin
            state_nxt = PAUSE;
          end else if (tick_en) begin
            cnt_ld = 1'b0;
          end
        end
        PAUSE: begin
          if (!pause) begin
            state_nxt = RUN;
          end
        end
        DONE: begin
          if (cmd_valid) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // While reset is asserted the counter is held cleared and nothing else is driven.
    if (!RESET_N) begin
      state_nxt = IDLE;
      cnt_rst   = 1'b1;
      cnt_ld    = 1'b0;
      cnt_din   = '0;
      term      = 1'b0;
      iter_inc  = 1'b0;
      accept    = 1'b0;
      cmd_ready = 1'b0;
    end
  end

  // Status outputs decoded from state; the latched direction steers the counter.
  always_comb begin
    busy   = (state == LOAD) || (state == RUN) || (state == PAUSE);
    done   = (state == DONE);
    cnt_up = cmd_q.up;
  end

  // State register.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch and saturating completed-iteration counter (cleared by each new command).
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_q    <= '0;
      iter_cnt <= '0;
    end else if (accept) begin
      cmd_q    <= '{start: cmd_start, stop: cmd_end, up: cmd_up, reload: cmd_reload};
      iter_cnt <= '0;
    end else if (iter_inc && (iter_cnt != '1)) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench: cnt_seq_ctrl closed-loop with an N-bit loadable up/down counter.
module tb_cnt_seq_ctrl;
  import cnt_seq_pkg::*;

  localparam int N      = 4;
  localparam int ITER_W = 8;

  logic              clk        = 1'b0;
  logic              RESET_N    = 1'b0;
  logic              cmd_valid  = 1'b0;
  logic              cmd_ready;
  logic [N-1:0]      cmd_start  = '0;
  logic [N-1:0]      cmd_end    = '0;
  logic              cmd_up     = 1'b0;
  logic              cmd_reload = 1'b0;
  logic              tick_en    = 1'b0;
  logic              pause      = 1'b0;
  logic              abort      = 1'b0;
  logic [N-1:0]      cnt_q;
  logic              cnt_rst;
  logic              cnt_ld;
  logic              cnt_up;
  logic [N-1:0]      cnt_din;
  logic              busy;
  logic              done;
  logic              term;
  logic [ITER_W-1:0] iter_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.N(N), .ITER_W(ITER_W)) dut (
    .clk(clk), .RESET_N(RESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_up(cmd_up), .cmd_reload(cmd_reload),
    .tick_en(tick_en), .pause(pause), .abort(abort),
    .cnt_q(cnt_q), .cnt_rst(cnt_rst), .cnt_ld(cnt_ld), .cnt_up(cnt_up), .cnt_din(cnt_din),
    .busy(busy), .done(done), .term(term), .iter_cnt(iter_cnt)
  );

  // Partner counter: synchronous RESET, LD, else step by UP every edge.
  always_ff @(posedge clk) begin
    if (cnt_rst)     cnt_q <= '0;
    else if (cnt_ld) cnt_q <= cnt_din;
    else if (cnt_up) cnt_q <= cnt_q + 1'b1;
    else             cnt_q <= cnt_q - 1'b1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Handshake a command, check the LOAD cycle, and return in RUN cycle 0.
  task automatic issue_cmd(input logic [N-1:0] s, input logic [N-1:0] e, input logic u, input logic r);
    cmd_start = s; cmd_end = e; cmd_up = u; cmd_reload = r; cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept_ready: got %b expected 1", cmd_ready);
    end
    next_cycle();
    cmd_valid = 1'b0;
    #1;
    checks++;
    if ({busy, cnt_ld, cnt_rst, cmd_ready} !== 4'b1100 || cnt_din !== s || cnt_up !== u) begin
      errors++;
      $display("FAIL load_cycle: busy/ld/rst/rdy=%b din=%h up=%b expected 1100 din=%h up=%b",
               {busy, cnt_ld, cnt_rst, cmd_ready}, cnt_din, cnt_up, s, u);
    end
    next_cycle();
    checks++;
    if (cnt_q !== s || busy !== 1'b1) begin
      errors++; $display("FAIL run_entry: cnt_q=%h busy=%b expected %h 1", cnt_q, busy, s);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({cnt_rst, cnt_ld, cnt_up, cmd_ready, busy, done, term} !== 7'b1000000 ||
        cnt_din !== '0 || iter_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rst/ld/up/rdy/busy/done/term=%b din=%h iter=%h expected 1000000 0 0",
               {cnt_rst, cnt_ld, cnt_up, cmd_ready, busy, done, term}, cnt_din, iter_cnt);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (cnt_q !== '0) begin
      errors++; $display("FAIL reset_counter: cnt_q=%h expected 0", cnt_q);
    end
    RESET_N = 1'b1;
    #1;
    checks++;
    if ({cnt_rst, cnt_ld, cmd_ready, busy} !== 4'b0110 || cnt_din !== '0) begin
      errors++;
      $display("FAIL idle_hold: rst/ld/rdy/busy=%b din=%h expected 0110 0",
               {cnt_rst, cnt_ld, cmd_ready, busy}, cnt_din);
    end
  endtask

  task automatic test_up_done();
    tick_en = 1'b1;
    issue_cmd(4'd3, 4'd7, 1'b1, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (cnt_q !== 4'(3 + k) || term !== (k == 4)) begin
        errors++; $display("FAIL up_step%0d: cnt_q=%h term=%b expected %h %b", k, cnt_q, term, 4'(3 + k), k == 4);
      end
      if (k == 2) begin
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++; $display("FAIL busy_reject: cmd_ready=%b expected 0", cmd_ready);
        end
        cmd_valid = 1'b0;
      end
      next_cycle();
    end
    checks++;
    if ({done, busy, cmd_ready} !== 3'b101 || cnt_q !== 4'd7 || iter_cnt !== 8'd1) begin
      errors++;
      $display("FAIL up_done: done/busy/rdy=%b cnt_q=%h iter=%0d expected 101 7 1",
               {done, busy, cmd_ready}, cnt_q, iter_cnt);
    end
    repeat (3) next_cycle();
    checks++;
    if (cnt_q !== 4'd7 || term !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL done_hold: cnt_q=%h term=%b done=%b expected 7 0 1", cnt_q, term, done);
    end
  endtask

  task automatic test_down_wrap();
    logic [N-1:0] seq [5] = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    issue_cmd(4'd2, 4'd14, 1'b0, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (cnt_q !== seq[k] || term !== (k == 4)) begin
        errors++; $display("FAIL down_step%0d: cnt_q=%h term=%b expected %h %b", k, cnt_q, term, seq[k], k == 4);
      end
      next_cycle();
    end
    checks++;
    if (done !== 1'b1 || cnt_q !== 4'd14 || iter_cnt !== 8'd1) begin
      errors++; $display("FAIL down_done: done=%b cnt_q=%h iter=%0d expected 1 e 1", done, cnt_q, iter_cnt);
    end
  endtask

  task automatic test_reload();
    issue_cmd(4'd0, 4'd3, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (cnt_q !== 4'(k % 4) || term !== ((k % 4) == 3)) begin
        errors++; $display("FAIL reload_k%0d: cnt_q=%h term=%b expected %h %b", k, cnt_q, term, 4'(k % 4), (k % 4) == 3);
      end
      next_cycle();
    end
    checks++;
    if (iter_cnt !== 8'd5 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reload_iter: iter=%0d busy=%b done=%b expected 5 1 0", iter_cnt, busy, done);
    end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    next_cycle();
    checks++;
    if (cmd_ready !== 1'b1 || cnt_q !== '0) begin
      errors++; $display("FAIL reload_abort_idle: cmd_ready=%b cnt_q=%h expected 1 0", cmd_ready, cnt_q);
    end
  endtask

  task automatic test_pause();
    int pexp [23] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 5, 5, 5, 5, 5, 5, 6, 6, 7, 7, 8, 8};
    issue_cmd(4'd0, 4'd12, 1'b1, 1'b0);
    for (int c = 0; c < 23; c++) begin
      pause   = (c >= 9) && (c <= 14);
      tick_en = (c % 2) == 0;
      #1;
      checks++;
      if (cnt_q !== 4'(pexp[c]) || term !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL pause_c%0d: cnt_q=%h term=%b busy=%b expected %h 0 1", c, cnt_q, term, busy, 4'(pexp[c]));
      end
      next_cycle();
    end
    pause   = 1'b0;
    tick_en = 1'b0;
  endtask

  task automatic test_abort();
    abort = 1'b1;
    #1;
    checks++;
    if (cnt_q !== 4'd9 || term !== 1'b0 || cmd_ready !== 1'b0 || cnt_ld !== 1'b1 || cnt_din !== 4'd9) begin
      errors++;
      $display("FAIL abort_cycle: cnt_q=%h term=%b rdy=%b ld=%b din=%h expected 9 0 0 1 9",
               cnt_q, term, cmd_ready, cnt_ld, cnt_din);
    end
    next_cycle();
    abort = 1'b0;
    #1;
    checks++;
    if ({cnt_rst, cnt_ld, busy, cmd_ready} !== 4'b1000 || cnt_q !== 4'd9) begin
      errors++;
      $display("FAIL clr_cycle: rst/ld/busy/rdy=%b cnt_q=%h expected 1000 9", {cnt_rst, cnt_ld, busy, cmd_ready}, cnt_q);
    end
    next_cycle();
    checks++;
    if (cnt_q !== '0 || {cmd_ready, busy, done, cnt_rst} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_idle: cnt_q=%h rdy/busy/done/rst=%b expected 0 1000", cnt_q, {cmd_ready, busy, done, cnt_rst});
    end
  endtask

  task automatic test_async_reset();
    tick_en = 1'b1;
    issue_cmd(4'd0, 4'd15, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #4;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({busy, cnt_rst, cnt_ld, cmd_ready, done, term} !== 6'b010000 || iter_cnt !== '0 || cnt_q !== 4'd3) begin
      errors++;
      $display("FAIL async_reset: busy/rst/ld/rdy/done/term=%b iter=%0d cnt_q=%h expected 010000 0 3",
               {busy, cnt_rst, cnt_ld, cmd_ready, done, term}, iter_cnt, cnt_q);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (cnt_q !== '0) begin
      errors++; $display("FAIL async_reset_clear: cnt_q=%h expected 0", cnt_q);
    end
    RESET_N = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt_up !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: rdy=%b busy=%b up=%b expected 1 0 0", cmd_ready, busy, cnt_up);
    end
    issue_cmd(4'd5, 4'd5, 1'b1, 1'b0);
    checks++;
    if (term !== 1'b1 || iter_cnt !== 8'd0) begin
      errors++; $display("FAIL zero_step_term: term=%b iter=%0d expected 1 0", term, iter_cnt);
    end
    next_cycle();
    checks++;
    if (done !== 1'b1 || iter_cnt !== 8'd1 || cnt_q !== 4'd5 || term !== 1'b0) begin
      errors++;
      $display("FAIL zero_step_done: done=%b iter=%0d cnt_q=%h term=%b expected 1 1 5 0", done, iter_cnt, cnt_q, term);
    end
  endtask

  task automatic test_saturate();
    issue_cmd(4'd5, 4'd5, 1'b1, 1'b1);
    repeat (260) next_cycle();
    checks++;
    if (iter_cnt !== 8'hFF || term !== 1'b1 || cnt_q !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL iter_saturate: iter=%h term=%b cnt_q=%h busy=%b expected ff 1 5 1", iter_cnt, term, cnt_q, busy);
    end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    next_cycle();
    checks++;
    if (cmd_ready !== 1'b1 || cnt_q !== '0 || iter_cnt !== 8'hFF) begin
      errors++; $display("FAIL saturate_abort: rdy=%b cnt_q=%h iter=%h expected 1 0 ff", cmd_ready, cnt_q, iter_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_up_done();
    test_down_wrap();
    test_reload();
    test_pause();
    test_abort();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
